// File: rtl/edge_bbox_tracker.sv
// edge_bbox_tracker
//   Accumulates the bounding box and the set-pixel count of the binary
//   ProcessOut stream over each video frame. At every frame boundary it
//   publishes the result to the tracking logic over a valid/ack handshake.
//
// Ports
//   CLK          pixel clock
//   RST          asynchronous reset, active-low
//   VDE          video data enable, high during active pixels
//   VSync        vertical sync, active-high; rising edge marks a frame boundary
//   ProcessIn    binary pixel from the filter chain, valid while VDE=1
//   ResultAck    consumer accepts the published result
//   ResultValid  published result is pending
//   Found        published frame had at least MIN_COUNT set pixels
//   BoxXMin/Max  leftmost / rightmost set column (0 when Found=0)
//   BoxYMin/Max  topmost / bottommost set line (0 when Found=0)
//   PixCount     set pixels in the published frame (saturating)
//   Overrun      sticky: a pending result was overwritten before its ack
module edge_bbox_tracker #(
  parameter int unsigned XW        = 11,
  parameter int unsigned YW        = 11,
  parameter int unsigned CW        = 21,
  parameter int unsigned MIN_COUNT = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          VDE,
  input  logic          VSync,
  input  logic          ProcessIn,
  input  logic          ResultAck,
  output logic          ResultValid,
  output logic          Found,
  output logic [XW-1:0] BoxXMin,
  output logic [XW-1:0] BoxXMax,
  output logic [YW-1:0] BoxYMin,
  output logic [YW-1:0] BoxYMax,
  output logic [CW-1:0] PixCount,
  output logic          Overrun
);

  localparam logic [XW-1:0] X_MAX   = '1;
  localparam logic [YW-1:0] Y_MAX   = '1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACCUM      = 2'd1,
    PUBLISH    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          vs_q, vde_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [XW-1:0] xmin_q, xmax_q;
  logic [YW-1:0] ymin_q, ymax_q;
  logic [CW-1:0] cnt_q;

  logic          fs_c, le_c, line_start_c;
  logic [XW-1:0] pix_x_c;
  logic          hit_c, clr_acc_c, publish_c, found_c;

  // Frame start, line end and line start strobes
  assign fs_c         = VSync & ~vs_q;
  assign le_c         = ~VDE & vde_q;
  assign line_start_c = VDE & ~vde_q;

  // Column of the current pixel: the first active cycle of a line is column 0
  assign pix_x_c = line_start_c ? '0 : x_q;

  assign found_c = (cnt_q >= CW'(MIN_COUNT));

  // Edge-detect registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vs_q  <= 1'b0;
      vde_q <= 1'b0;
    end else begin
      vs_q  <= VSync;
      vde_q <= VDE;
    end
  end

  // Column / line counters, both saturating
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      if (VDE) begin
        x_q <= (pix_x_c == X_MAX) ? X_MAX : pix_x_c + XW'(1);
      end
      if (fs_c) begin
        y_q <= '0;
      end else if (le_c && (y_q != Y_MAX)) begin
        y_q <= y_q + YW'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= WAIT_FRAME;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and control strobes
  always_comb begin
    state_d   = state_q;
    clr_acc_c = 1'b0;
    publish_c = 1'b0;
    hit_c     = 1'b0;
    unique case (state_q)
      WAIT_FRAME: begin
        // The frame in progress at reset is partial and never published
        if (fs_c) begin
          state_d   = ACCUM;
          clr_acc_c = 1'b1;
        end
      end
      ACCUM: begin
        // A set pixel coinciding with the frame boundary is dropped
        if (fs_c) begin
          state_d = PUBLISH;
        end else begin
          hit_c = VDE & ProcessIn;
        end
      end
      PUBLISH: begin
        publish_c = 1'b1;
        clr_acc_c = 1'b1;
        state_d   = ACCUM;
      end
      default: begin
        state_d = WAIT_FRAME;
      end
    endcase
  end

  // Per-frame bounding box and set-pixel accumulators
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      xmin_q <= '1;
      xmax_q <= '0;
      ymin_q <= '1;
      ymax_q <= '0;
      cnt_q  <= '0;
    end else if (clr_acc_c) begin
      xmin_q <= '1;
      xmax_q <= '0;
      ymin_q <= '1;
      ymax_q <= '0;
      cnt_q  <= '0;
    end else if (hit_c) begin
      if (pix_x_c < xmin_q) xmin_q <= pix_x_c;
      if (pix_x_c > xmax_q) xmax_q <= pix_x_c;
      if (y_q < ymin_q)     ymin_q <= y_q;
      if (y_q > ymax_q)     ymax_q <= y_q;
      if (cnt_q != CNT_MAX) cnt_q  <= cnt_q + CW'(1);
    end
  end

  // Published result and handshake; a publish always wins over a pending ack
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ResultValid <= 1'b0;
      Found       <= 1'b0;
      BoxXMin     <= '0;
      BoxXMax     <= '0;
      BoxYMin     <= '0;
      BoxYMax     <= '0;
      PixCount    <= '0;
      Overrun     <= 1'b0;
    end else if (publish_c) begin
      ResultValid <= 1'b1;
      Found       <= found_c;
      BoxXMin     <= found_c ? xmin_q : '0;
      BoxXMax     <= found_c ? xmax_q : '0;
      BoxYMin     <= found_c ? ymin_q : '0;
      BoxYMax     <= found_c ? ymax_q : '0;
      PixCount    <= cnt_q;
      // An ack in the publish cycle retires the old result, so no overrun
      if (ResultValid && !ResultAck) begin
        Overrun <= 1'b1;
      end
    end else if (ResultValid && ResultAck) begin
      ResultValid <= 1'b0;
      Overrun     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_edge_bbox_tracker.sv
// Randomized frame stimulus against a per-frame reference model. Two
// instances share the inputs: one with default widths, one narrow so that
// column, line and count saturation are reached by small frames.
module tb_edge_bbox_tracker;

  logic CLK = 1'b0;
  logic RST, VDE, VSync, ProcessIn, ResultAck;

  logic        a_valid, a_found, a_over;
  logic [10:0] a_xmin, a_xmax, a_ymin, a_ymax;
  logic [20:0] a_cnt;

  logic        b_valid, b_found, b_over;
  logic [3:0]  b_xmin, b_xmax;
  logic [2:0]  b_ymin, b_ymax;
  logic [4:0]  b_cnt;

  edge_bbox_tracker dut_a (
    .CLK(CLK), .RST(RST), .VDE(VDE), .VSync(VSync), .ProcessIn(ProcessIn),
    .ResultAck(ResultAck), .ResultValid(a_valid), .Found(a_found),
    .BoxXMin(a_xmin), .BoxXMax(a_xmax), .BoxYMin(a_ymin), .BoxYMax(a_ymax),
    .PixCount(a_cnt), .Overrun(a_over)
  );

  edge_bbox_tracker #(.XW(4), .YW(3), .CW(5), .MIN_COUNT(1)) dut_b (
    .CLK(CLK), .RST(RST), .VDE(VDE), .VSync(VSync), .ProcessIn(ProcessIn),
    .ResultAck(ResultAck), .ResultValid(b_valid), .Found(b_found),
    .BoxXMin(b_xmin), .BoxXMax(b_xmax), .BoxYMin(b_ymin), .BoxYMax(b_ymax),
    .PixCount(b_cnt), .Overrun(b_over)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  // Model: per-instance limits, expected outputs, current-frame statistics
  int xlim[2] = '{2047, 15};
  int ylim[2] = '{2047, 7};
  int clim[2] = '{2097151, 31};
  int minc[2] = '{16, 1};

  int e_valid, e_over;
  int e_found[2], e_xmin[2], e_xmax[2], e_ymin[2], e_ymax[2], e_cnt[2];
  bit armed;
  int f_cnt, f_xmin, f_xmax, f_ymin, f_ymax;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic frame_clear();
    f_cnt  = 0;
    f_xmin = 1 << 30;
    f_xmax = 0;
    f_ymin = 1 << 30;
    f_ymax = 0;
  endtask

  task automatic model_reset();
    e_valid = 0;
    e_over  = 0;
    for (int k = 0; k < 2; k++) begin
      e_found[k] = 0; e_xmin[k] = 0; e_xmax[k] = 0;
      e_ymin[k]  = 0; e_ymax[k] = 0; e_cnt[k]  = 0;
    end
    armed = 0;
    frame_clear();
  endtask

  task automatic model_publish(input bit ack);
    if (e_valid != 0 && !ack) e_over = 1;
    e_valid = 1;
    for (int k = 0; k < 2; k++) begin
      e_cnt[k]   = imin(f_cnt, clim[k]);
      e_found[k] = (e_cnt[k] >= minc[k]) ? 1 : 0;
      e_xmin[k]  = e_found[k] ? imin(f_xmin, xlim[k]) : 0;
      e_xmax[k]  = e_found[k] ? imin(f_xmax, xlim[k]) : 0;
      e_ymin[k]  = e_found[k] ? imin(f_ymin, ylim[k]) : 0;
      e_ymax[k]  = e_found[k] ? imin(f_ymax, ylim[k]) : 0;
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".a.valid"}, 32'(a_valid), e_valid);
    chk({tag, ".a.over"},  32'(a_over),  e_over);
    chk({tag, ".a.found"}, 32'(a_found), e_found[0]);
    chk({tag, ".a.xmin"},  32'(a_xmin),  e_xmin[0]);
    chk({tag, ".a.xmax"},  32'(a_xmax),  e_xmax[0]);
    chk({tag, ".a.ymin"},  32'(a_ymin),  e_ymin[0]);
    chk({tag, ".a.ymax"},  32'(a_ymax),  e_ymax[0]);
    chk({tag, ".a.cnt"},   32'(a_cnt),   e_cnt[0]);
    chk({tag, ".b.valid"}, 32'(b_valid), e_valid);
    chk({tag, ".b.over"},  32'(b_over),  e_over);
    chk({tag, ".b.found"}, 32'(b_found), e_found[1]);
    chk({tag, ".b.xmin"},  32'(b_xmin),  e_xmin[1]);
    chk({tag, ".b.xmax"},  32'(b_xmax),  e_xmax[1]);
    chk({tag, ".b.ymin"},  32'(b_ymin),  e_ymin[1]);
    chk({tag, ".b.ymax"},  32'(b_ymax),  e_ymax[1]);
    chk({tag, ".b.cnt"},   32'(b_cnt),   e_cnt[1]);
  endtask

  // Frame boundary: VSync rises, then the publish edge one cycle later
  task automatic vsync_pulse(input bit ack_pub, input string tag);
    VSync = 1'b1; VDE = 1'b0; ResultAck = 1'b0;
    tick();
    ResultAck = ack_pub;
    @(negedge CLK);
    chk({tag, ".pre.valid"}, 32'(a_valid), e_valid);
    chk({tag, ".pre.cnt"},   32'(b_cnt),   e_cnt[1]);
    tick();
    ResultAck = 1'b0;
    VSync     = 1'b0;
    if (armed) begin
      model_publish(ack_pub);
    end else if (ack_pub && e_valid != 0) begin
      e_valid = 0;
      e_over  = 0;
    end
    armed = 1;
    frame_clear();
    @(negedge CLK);
    check_outs(tag);
  endtask

  task automatic do_ack(input string tag);
    ResultAck = 1'b1;
    tick();
    ResultAck = 1'b0;
    if (e_valid != 0) begin
      e_valid = 0;
      e_over  = 0;
    end
    @(negedge CLK);
    check_outs(tag);
  endtask

  // mode 0: random with density dens (percent); 1: two fixed pixels; 2: three fixed pixels
  function automatic bit pix_at(input int mode, input int c, input int r, input int dens);
    case (mode)
      1:       return (c == 2 && r == 1) || (c == 5 && r == 3);
      2:       return (c == 1 && r == 0) || (c == 3 && r == 2) || (c == 7 && r == 3);
      default: return $urandom_range(99) < dens;
    endcase
  endfunction

  task automatic drive_frame(input int w, input int h, input int mode, input int dens);
    bit p;
    repeat (2) begin
      VDE = 1'b0; ProcessIn = 1'($urandom); tick();
    end
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        p = pix_at(mode, c, r, dens);
        VDE = 1'b1; ProcessIn = p;
        if (p) begin
          f_cnt++;
          f_xmin = imin(f_xmin, c);
          f_xmax = (c > f_xmax) ? c : f_xmax;
          f_ymin = imin(f_ymin, r);
          f_ymax = (r > f_ymax) ? r : f_ymax;
        end
        tick();
      end
      // Horizontal blanking with garbage on ProcessIn, which must be ignored
      repeat (3) begin
        VDE = 1'b0; ProcessIn = 1'($urandom); tick();
      end
    end
  endtask

  initial begin
    int w, h, dens, ackm;
    RST = 1'b0; VDE = 1'b0; VSync = 1'b0; ProcessIn = 1'b0; ResultAck = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_outs("reset");
    tick();
    RST = 1'b1;

    // Partial frame before the first boundary is never published
    drive_frame(6, 2, 0, 50);
    vsync_pulse(1'b0, "arm");

    drive_frame(8, 4, 1, 0);
    vsync_pulse(1'b0, "small");
    do_ack("small.ack");

    drive_frame(8, 4, 0, 0);
    vsync_pulse(1'b0, "zero");
    do_ack("zero.ack");

    drive_frame(8, 4, 2, 0);
    vsync_pulse(1'b0, "below");

    drive_frame(10, 5, 0, 40);
    vsync_pulse(1'b0, "overrun");
    do_ack("overrun.ack");

    drive_frame(9, 6, 0, 30);
    vsync_pulse(1'b0, "pend");
    drive_frame(12, 4, 0, 60);
    vsync_pulse(1'b1, "ackpub");

    for (int i = 0; i < 24; i++) begin
      w    = $urandom_range(20, 1);
      h    = $urandom_range(10, 1);
      dens = (i % 4 == 0) ? 100 : int'($urandom_range(60));
      ackm = int'($urandom_range(2));
      drive_frame(w, h, 0, dens);
      if (ackm == 1) do_ack($sformatf("rnd%0d.ack", i));
      vsync_pulse(ackm == 2, $sformatf("rnd%0d", i));
    end

    // Dense pending result, then reset in the middle of the next line
    drive_frame(16, 8, 0, 100);
    vsync_pulse(1'b0, "dense");
    repeat (2) begin
      VDE = 1'b0; tick();
    end
    repeat (5) begin
      VDE = 1'b1; ProcessIn = 1'b1; tick();
    end
    RST = 1'b0;
    #1;
    model_reset();
    check_outs("midrst");
    tick();
    RST = 1'b1;
    drive_frame(10, 3, 0, 50);
    vsync_pulse(1'b0, "rst.arm");
    drive_frame(7, 5, 0, 50);
    vsync_pulse(1'b0, "rst.first");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
